key_sequencer: RTL

KEY_SEQUENCER -- requirements
Module: key_sequencer

---
 rtl/key_if.sv | 42 ++++
 rtl/key_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/key_if.sv
// ----------------------------------------------------------------------------
// key_if -- keypad-side bus of the key sequencer.
//
// Signals:
//   key_code    [3:0]          translated key (0-9 digit, A/B/E op, C clear,
//                              D equals, F '#')
//   key_valid                  one-cycle strobe qualifying key_code
//   operand_a   [4*N_DIGITS-1:0] first operand, packed BCD, LSD in [3:0]
//   operand_b   [4*N_DIGITS-1:0] second operand, packed BCD, LSD in [3:0]
//   op_code     [1:0]          latched operator (A=01, B=10, '*'=11, none=00)
//   calc_start                 one-cycle pulse, operands/op_code valid
//   clear_pulse                one-cycle pulse on accepted clear
//   err_pulse                  one-cycle pulse on rejected key
//   state_o     [1:0]          current sequencer state
//
// Modports: master = keypad / consumer side, slave = key_sequencer.
// ----------------------------------------------------------------------------
interface key_if #(
    parameter int N_DIGITS = 4
);
    logic [3:0]            key_code;
    logic                  key_valid;
    logic [4*N_DIGITS-1:0] operand_a;
    logic [4*N_DIGITS-1:0] operand_b;
    logic [1:0]            op_code;
    logic                  calc_start;
    logic                  clear_pulse;
    logic                  err_pulse;
    logic [1:0]            state_o;

    modport master (
        output key_code, key_valid,
        input  operand_a, operand_b, op_code,
        input  calc_start, clear_pulse, err_pulse, state_o
    );

    modport slave (
        input  key_code, key_valid,
        output operand_a, operand_b, op_code,
        output calc_start, clear_pulse, err_pulse, state_o
    );
endinterface

// File: rtl/key_sequencer.sv
// ----------------------------------------------------------------------------
// key_sequencer -- collects two BCD operands and an operator from a keypad
// and issues a one-cycle calc_start when equals completes the expression.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    key_if.slave: key_code/key_valid in; operands, op_code,
//          calc_start, clear_pulse, err_pulse, state_o out (all registered)
//
// Parameter:
//   N_DIGITS  maximum decimal digits per operand (1..8)
//
// Build option:
//   BACKSPACE_EN  when defined, '#' deletes the last entered digit of the
//                 operand being edited; otherwise '#' is silently ignored.
// ----------------------------------------------------------------------------
module key_sequencer #(
    parameter int N_DIGITS = 4
) (
    input logic  clk,
    input logic  rst_n,
    key_if.slave bus
);
    localparam int         W       = 4 * N_DIGITS;
    localparam logic [3:0] MAX_CNT = 4'(N_DIGITS);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_OP   = 2'b01,
        S_B    = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [3:0]     cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic           calc_q, calc_d, clr_q, clr_d, err_q, err_d;
    logic           armed_q;

    // Low for the first edge after reset release so a key strobe that
    // overlaps the release cycle is dropped.
    logic key_accept;
    assign key_accept = bus.key_valid && armed_q;

    logic is_digit, is_op, is_clear, is_equals;
    assign is_digit  = (bus.key_code <= 4'h9);
    assign is_op     = (bus.key_code == 4'hA) || (bus.key_code == 4'hB) ||
                       (bus.key_code == 4'hE);
    assign is_clear  = (bus.key_code == 4'hC);
    assign is_equals = (bus.key_code == 4'hD);
`ifdef BACKSPACE_EN
    logic is_hash;
    assign is_hash   = (bus.key_code == 4'hF);
`endif

    logic [1:0] op_map;
    always_comb begin
        unique case (bus.key_code)
            4'hA:    op_map = 2'b01;
            4'hB:    op_map = 2'b10;
            4'hE:    op_map = 2'b11;
            default: op_map = 2'b00;
        endcase
    end

    // NOTE: every signal gets its hold value before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        calc_d  = 1'b0;
        clr_d   = 1'b0;
        err_d   = 1'b0;

        if (key_accept) begin
            if (is_clear) begin
                state_d = S_A;
                a_d     = '0;
                b_d     = '0;
                op_d    = 2'b00;
                cnt_a_d = '0;
                cnt_b_d = '0;
                clr_d   = 1'b1;
            end else begin
                unique case (state_q)
                    S_A: begin
                        if (is_digit) begin
                            if (cnt_a_q == MAX_CNT) begin
                                err_d = 1'b1;
                            end else begin
                                a_d     = (a_q << 4) | W'(bus.key_code);
                                cnt_a_d = cnt_a_q + 4'd1;
                            end
                        end else if (is_op) begin
                            op_d    = op_map;
                            state_d = S_OP;
                        end else if (is_equals) begin
                            err_d = 1'b1;
`ifdef BACKSPACE_EN
                        end else if (is_hash) begin
                            if (cnt_a_q != 4'd0) begin
                                a_d     = a_q >> 4;
                                cnt_a_d = cnt_a_q - 4'd1;
                            end else begin
                                err_d = 1'b1;
                            end
`endif
                        end
                    end
                    S_OP: begin
                        if (is_digit) begin
                            b_d     = W'(bus.key_code);
                            cnt_b_d = 4'd1;
                            state_d = S_B;
                        end else if (is_op) begin
                            op_d = op_map;
                        end else if (is_equals) begin
                            err_d = 1'b1;
`ifdef BACKSPACE_EN
                        end else if (is_hash) begin
                            err_d = 1'b1;
`endif
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            if (cnt_b_q == MAX_CNT) begin
                                err_d = 1'b1;
                            end else begin
                                b_d     = (b_q << 4) | W'(bus.key_code);
                                cnt_b_d = cnt_b_q + 4'd1;
                            end
                        end else if (is_op) begin
                            err_d = 1'b1;
                        end else if (is_equals) begin
                            calc_d  = 1'b1;
                            state_d = S_DONE;
`ifdef BACKSPACE_EN
                        end else if (is_hash) begin
                            if (cnt_b_q != 4'd0) begin
                                b_d     = b_q >> 4;
                                cnt_b_d = cnt_b_q - 4'd1;
                            end else begin
                                err_d = 1'b1;
                            end
`endif
                        end
                    end
                    S_DONE: begin
                        // A digit starts a fresh expression without a clear.
                        if (is_digit) begin
                            a_d     = W'(bus.key_code);
                            b_d     = '0;
                            op_d    = 2'b00;
                            cnt_a_d = 4'd1;
                            cnt_b_d = '0;
                            state_d = S_A;
                        end else if (is_op || is_equals) begin
                            err_d = 1'b1;
`ifdef BACKSPACE_EN
                        end else if (is_hash) begin
                            err_d = 1'b1;
`endif
                        end
                    end
                    default: state_d = S_A;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            calc_q  <= 1'b0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            calc_q  <= calc_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
            armed_q <= 1'b1;
        end
    end

    assign bus.operand_a   = a_q;
    assign bus.operand_b   = b_q;
    assign bus.op_code     = op_q;
    assign bus.calc_start  = calc_q;
    assign bus.clear_pulse = clr_q;
    assign bus.err_pulse   = err_q;
    assign bus.state_o     = state_q;

endmodule
